// File: rtl/spi_slave_fifo.sv
// SPI target endpoint: pins oversampled in the clk domain, MSB-first words,
// TX/RX FIFOs on the host side and a sticky, maskable interrupt block.
module spi_slave_fifo #(
  parameter int unsigned MODE       = 0,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          ss_n,
  input  logic                          mosi,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic                          tx_wr_en,
  input  logic [DATA_WIDTH-1:0]         tx_wr_data,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  input  logic                          rx_rd_en,
  output logic [DATA_WIDTH-1:0]         rx_rd_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  input  logic [3:0]                    irq_enable,
  input  logic [3:0]                    irq_clear,
  output logic [3:0]                    irq_status,
  output logic                          irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic CPOL = 1'((MODE >> 1) & 1);
  localparam logic CPHA = 1'(MODE & 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] WORD_DONE = CW'(DATA_WIDTH);
  localparam logic [LW-1:0] DEPTH     = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  // [0],[1] = synchroniser, [2] = history used for edge detection
  logic [2:0] sclk_q, ss_q, mosi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= {3{CPOL}};
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      ss_q   <= {ss_q[1:0], ss_n};
      mosi_q <= {mosi_q[1:0], mosi};
    end
  end

  logic lead_edge, trail_edge, ss_fall, ss_high, mosi_s;
  assign lead_edge  = (sclk_q[1] != CPOL) && (sclk_q[2] == CPOL);
  assign trail_edge = (sclk_q[1] == CPOL) && (sclk_q[2] != CPOL);
  assign ss_fall    = !ss_q[1] && ss_q[2];
  assign ss_high    = ss_q[1];
  assign mosi_s     = mosi_q[2];

  // TX FIFO
  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         tx_wr_q, tx_rd_q;
  logic [LW-1:0]         tx_cnt_q;
  logic                  tx_push, tx_pop, tx_empty;

  assign tx_full  = (tx_cnt_q == DEPTH);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = tx_wr_en && !tx_full;
  assign tx_level = tx_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) tx_mem_q[i] <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) begin
        tx_mem_q[tx_wr_q] <= tx_wr_data;
        tx_wr_q           <= tx_wr_q + 1'b1;
      end
      if (tx_pop) tx_rd_q <= tx_rd_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
    end
  end

  // RX FIFO
  logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         rx_wr_q, rx_rd_q;
  logic [LW-1:0]         rx_cnt_q;
  logic                  rx_push_req, rx_push, rx_pop, rx_full, rx_ovf;
  logic [DATA_WIDTH-1:0] rx_word;

  assign rx_full    = (rx_cnt_q == DEPTH);
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_pop     = rx_rd_en && !rx_empty;
  // A same-cycle pop frees a slot, so a push at full is still accepted
  assign rx_push    = rx_push_req && (!rx_full || rx_pop);
  assign rx_ovf     = rx_push_req && rx_full && !rx_pop;
  assign rx_level   = rx_cnt_q;
  assign rx_rd_data = rx_mem_q[rx_rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) rx_mem_q[i] <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) begin
        rx_mem_q[rx_wr_q] <= rx_word;
        rx_wr_q           <= rx_wr_q + 1'b1;
      end
      if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
    end
  end

  // Shift engine
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [3:0]            irq_status_q, irq_status_d, ev;
  logic                  irq_q;
  logic                  do_load, sample_e, shift_e;

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_pop      = 1'b0;
    rx_push_req = 1'b0;
    rx_word     = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
    do_load     = 1'b0;
    ev          = '0;
    sample_e    = CPHA ? trail_edge : lead_edge;
    shift_e     = CPHA ? (lead_edge && bit_cnt_q != '0)
                       : (trail_edge && bit_cnt_q != WORD_DONE);

    unique case (state_q)
      IDLE: if (ss_fall) state_d = LOAD;
      LOAD: begin
        if (ss_high) begin
          state_d = IDLE;
        end else begin
          do_load = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_high) begin
          state_d    = IDLE;
          // WORD_DONE means the last word completed; only CPHA=0 parks there
          ev[3]      = (bit_cnt_q != '0) && (bit_cnt_q != WORD_DONE);
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end else begin
          if (sample_e) begin
            rx_shift_d = rx_word;
            if (bit_cnt_q == LAST_BIT) begin
              rx_push_req = 1'b1;
              if (CPHA) do_load = 1'b1;
              else      bit_cnt_d = WORD_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          if (shift_e) tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          if (!CPHA && trail_edge && bit_cnt_q == WORD_DONE) do_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      bit_cnt_d = '0;
      if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_mem_q[tx_rd_q];
      end else begin
        tx_shift_d = '0;
        ev[2]      = 1'b1;
      end
    end

    ev[0] = rx_push_req;
    ev[1] = rx_ovf;
    irq_status_d = (irq_status_q & ~irq_clear) | ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      bit_cnt_q    <= '0;
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      irq_status_q <= irq_status_d;
      irq_q        <= |(irq_status_q & irq_enable);
    end
  end

  assign miso       = tx_shift_q[DATA_WIDTH-1];
  assign miso_oe    = (state_q != IDLE);
  assign irq_status = irq_status_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Directed bench for spi_slave_fifo in mode 0: acts as SPI master and host.
module tb_spi_slave_fifo;

  logic        clk = 1'b0;
  logic        rst, sclk, ss_n, mosi;
  logic        miso, miso_oe;
  logic        tx_wr_en, tx_full, rx_rd_en, rx_empty, irq;
  logic [15:0] tx_wr_data, rx_rd_data;
  logic [2:0]  tx_level, rx_level;
  logic [3:0]  irq_enable, irq_clear, irq_status;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mtx [8];
  logic [15:0] mrx [8];

  spi_slave_fifo #(.MODE(0), .DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data), .tx_full(tx_full), .tx_level(tx_level),
    .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
    .irq_enable(irq_enable), .irq_clear(irq_clear), .irq_status(irq_status), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half();
    cyc(8);
  endtask

  task automatic push_tx(input logic [15:0] d);
    tx_wr_data = d; tx_wr_en = 1'b1; cyc(1); tx_wr_en = 1'b0;
  endtask

  task automatic pop_rx(input int n);
    rx_rd_en = 1'b1; cyc(n); rx_rd_en = 1'b0;
  endtask

  task automatic clr(input logic [3:0] m);
    irq_clear = m; cyc(1); irq_clear = '0;
  endtask

  // Clocks nbits of mtx[w]; with end_frame, ss_n rises together with the last sclk fall
  task automatic xfer(input int w, input int nbits, input bit end_frame);
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = 15 - i;
      mosi = mtx[w][b];
      half();
      sclk = 1'b1;
      mrx[w][b] = miso;
      half();
      sclk = 1'b0;
      if (end_frame && i == nbits - 1) ss_n = 1'b1;
    end
  endtask

  task automatic frame(input int n);
    ss_n = 1'b0;
    half();
    for (int w = 0; w < n; w++) xfer(w, 16, w == n - 1);
    cyc(8);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_miso"}, 32'(miso), 32'h0);
    chk({tag, "_miso_oe"}, 32'(miso_oe), 32'h0);
    chk({tag, "_irq"}, 32'(irq), 32'h0);
    chk({tag, "_irq_status"}, 32'(irq_status), 32'h0);
    chk({tag, "_tx_full"}, 32'(tx_full), 32'h0);
    chk({tag, "_tx_level"}, 32'(tx_level), 32'h0);
    chk({tag, "_rx_empty"}, 32'(rx_empty), 32'h1);
    chk({tag, "_rx_level"}, 32'(rx_level), 32'h0);
    chk({tag, "_rx_rd_data"}, 32'(rx_rd_data), 32'h0);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0;
    irq_enable = 4'b0001; irq_clear = '0;
    cyc(4);
    rst = 1'b0;
    cyc(4);
    chk_reset("por");

    // 1: single word exchange
    push_tx(16'hAA55);
    chk("t1_tx_level", 32'(tx_level), 32'd1);
    mtx[0] = 16'h1234;
    frame(1);
    chk("t1_miso_word", 32'(mrx[0]), 32'hAA55);
    chk("t1_rx_data", 32'(rx_rd_data), 32'h1234);
    chk("t1_rx_level", 32'(rx_level), 32'd1);
    chk("t1_irq_status", 32'(irq_status), 32'h1);
    chk("t1_irq", 32'(irq), 32'h1);
    chk("t1_tx_level_after", 32'(tx_level), 32'd0);
    pop_rx(1);
    chk("t1_rx_empty", 32'(rx_empty), 32'h1);
    irq_clear = 4'b0001; cyc(1); irq_clear = '0;
    chk("t1_status_cleared", 32'(irq_status), 32'h0);
    chk("t1_irq_lag", 32'(irq), 32'h1);
    cyc(1);
    chk("t1_irq_dropped", 32'(irq), 32'h0);

    // 2: three back-to-back words in one frame
    push_tx(16'h0000); push_tx(16'h1111); push_tx(16'h2222);
    chk("t2_tx_level", 32'(tx_level), 32'd3);
    mtx[0] = 16'hCCCC; mtx[1] = 16'hCCCC; mtx[2] = 16'hCCCC;
    frame(3);
    chk("t2_miso_w0", 32'(mrx[0]), 32'h0000);
    chk("t2_miso_w1", 32'(mrx[1]), 32'h1111);
    chk("t2_miso_w2", 32'(mrx[2]), 32'h2222);
    chk("t2_rx_level", 32'(rx_level), 32'd3);
    chk("t2_rx_data", 32'(rx_rd_data), 32'hCCCC);
    chk("t2_irq_status", 32'(irq_status), 32'h1);
    pop_rx(3);
    chk("t2_drained", 32'(rx_empty), 32'h1);
    pop_rx(1);
    chk("t2_empty_pop_hold", 32'(rx_level), 32'd0);
    clr(4'hF);

    // 3: RX overflow with TX empty
    mtx[0] = 16'h1001; mtx[1] = 16'h1002; mtx[2] = 16'h1003;
    mtx[3] = 16'h1004; mtx[4] = 16'h1005;
    frame(5);
    chk("t3_rx_level", 32'(rx_level), 32'd4);
    chk("t3_head", 32'(rx_rd_data), 32'h1001);
    chk("t3_irq_status", 32'(irq_status), 32'h7);
    clr(4'b0010);
    chk("t3_clear_ovf_only", 32'(irq_status), 32'h5);
    pop_rx(1);
    chk("t3_second", 32'(rx_rd_data), 32'h1002);
    pop_rx(3);
    chk("t3_drained", 32'(rx_empty), 32'h1);
    clr(4'hF);

    // 4: TX underflow
    mtx[0] = 16'h5A5A;
    frame(1);
    chk("t4_miso_zero", 32'(mrx[0]), 32'h0000);
    chk("t4_irq_status", 32'(irq_status), 32'h5);
    chk("t4_rx_data", 32'(rx_rd_data), 32'h5A5A);
    chk("t4_rx_level", 32'(rx_level), 32'd1);
    pop_rx(1);
    clr(4'hF);

    // 5: aborted frame after 7 bits, then a good frame
    mtx[0] = 16'hFFFF;
    ss_n = 1'b0;
    half();
    xfer(0, 7, 1'b0);
    half();
    ss_n = 1'b1;
    cyc(8);
    chk("t5_irq_status", 32'(irq_status), 32'hC);
    chk("t5_rx_level", 32'(rx_level), 32'd0);
    chk("t5_miso_oe", 32'(miso_oe), 32'h0);
    clr(4'hF);
    push_tx(16'h0F0F);
    mtx[0] = 16'h3C3C;
    frame(1);
    chk("t5_miso_word", 32'(mrx[0]), 32'h0F0F);
    chk("t5_rx_data", 32'(rx_rd_data), 32'h3C3C);
    chk("t5_irq_status_ok", 32'(irq_status), 32'h1);
    pop_rx(1);
    clr(4'hF);

    // 7: TX full boundary, write at full ignored
    push_tx(16'hA001); push_tx(16'hA002); push_tx(16'hA003); push_tx(16'hA004);
    chk("t7_tx_full", 32'(tx_full), 32'h1);
    push_tx(16'h9999);
    chk("t7_tx_level", 32'(tx_level), 32'd4);
    mtx[0] = 16'h0001; mtx[1] = 16'h0002; mtx[2] = 16'h0003; mtx[3] = 16'h0004;
    frame(4);
    chk("t7_miso_w0", 32'(mrx[0]), 32'hA001);
    chk("t7_miso_w3", 32'(mrx[3]), 32'hA004);
    chk("t7_tx_empty", 32'(tx_level), 32'd0);
    chk("t7_rx_level", 32'(rx_level), 32'd4);
    chk("t7_irq_status", 32'(irq_status), 32'h1);

    // 6: reset mid-frame at bit 9 with two TX words queued
    push_tx(16'hBEEF); push_tx(16'hCAFE);
    chk("t6_tx_level", 32'(tx_level), 32'd2);
    mtx[0] = 16'h1357;
    ss_n = 1'b0;
    half();
    xfer(0, 9, 1'b0);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    chk_reset("t6");
    ss_n = 1'b1;
    cyc(8);
    mtx[0] = 16'h7777;
    frame(1);
    chk("t6_miso_zero", 32'(mrx[0]), 32'h0000);
    chk("t6_irq_status", 32'(irq_status), 32'h5);
    chk("t6_rx_data", 32'(rx_rd_data), 32'h7777);
    chk("t6_rx_level", 32'(rx_level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_fifo.md
Name: spi_slave_fifo

Overview:
- SPI target (slave) endpoint that pairs with the team's spi_master across sclk/mosi/miso/ss_n.
- Oversamples the SPI pins in the system clock domain and shifts DATA_WIDTH-bit words, MSB first.
- Feeds transmit words from a TX FIFO written by the host, and stores received words in an RX FIFO read by the host.
- Raises a maskable interrupt on word reception, overflow, underflow and aborted frames.

Parameters:
- MODE, 0, SPI mode 0-3; CPOL = MODE[1], CPHA = MODE[0].
- DATA_WIDTH, 16, bits per SPI word.
- FIFO_DEPTH, 4, entries per FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  system clock; must run at least 8x sclk.
- rst  input  1  synchronous active-high reset.
- sclk  input  1  SPI clock from master (asynchronous).
- ss_n  input  1  active-low select for this slave (asynchronous).
- mosi  input  1  master-out data (asynchronous).
- miso  output  1  slave-out data.
- miso_oe  output  1  miso output enable; 1 while selected.
- tx_wr_en  input  1  push tx_wr_data into TX FIFO.
- tx_wr_data  input  DATA_WIDTH  word to transmit.
- tx_full  output  1  TX FIFO full.
- tx_level  output  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- rx_rd_en  input  1  pop RX FIFO.
- rx_rd_data  output  DATA_WIDTH  RX FIFO head (first-word fall-through).
- rx_empty  output  1  RX FIFO empty.
- rx_level  output  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- irq_enable  input  4  per-bit mask for irq_status.
- irq_clear  input  4  write-1-to-clear for irq_status.
- irq_status  output  4  sticky flags: [0] rx_done, [1] rx_overflow, [2] tx_underflow, [3] frame_abort.
- irq  output  1  |(irq_status & irq_enable), registered.

Behaviour:
- Reset values:
  - miso=0, miso_oe=0, irq=0, irq_status=0.
  - Both FIFOs empty: tx_full=0, tx_level=0, rx_empty=1, rx_level=0, rx_rd_data=0.
  - FSM in IDLE; shift registers and bit counter 0.
  - Reset mid-frame discards the partial word and both FIFO contents.
- Synchronisation:
  - sclk, ss_n and mosi each pass through a 2-flop synchroniser plus one history flop.
  - Edges are detected from the synchronised value vs. the history flop.
  - Pin-to-internal-event latency is 3 clk cycles.
- Leading edge = sclk transition away from CPOL; trailing edge = transition back to CPOL.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE:
    - miso_oe=0.
    - Synced ss_n falling edge -> LOAD.
  - LOAD (1 cycle):
    - If TX FIFO is non-empty, pop the head into tx_shift; otherwise load 0 and set tx_underflow.
    - bit_counter=0; miso_oe=1; miso=tx_shift[MSB].
    - -> SHIFT.
  - SHIFT, CPHA=0: sample mosi into rx_shift on the leading edge; shift tx_shift left (new MSB on miso) on the trailing edge.
  - SHIFT, CPHA=1: shift tx_shift on the leading edge, except the first leading edge, where the MSB is already presented from LOAD; sample on the trailing edge.
  - Word completion (DATA_WIDTH-th sample):
    - Push rx_shift into the RX FIFO and set rx_done.
    - If the RX FIFO is full, drop the word, set rx_overflow and leave FIFO contents unchanged.
    - Then act as LOAD in the same cycle as the last trailing edge, so back-to-back words work with ss_n held low.
  - Synced ss_n high in LOAD/SHIFT -> IDLE. If bit_counter is nonzero, discard the partial word and set frame_abort.
- miso is always driven from tx_shift[MSB]. miso_oe tracks state != IDLE.
- TX FIFO:
  - A write while tx_full is ignored, even if the SPI side pops in the same cycle.
  - An SPI pop and a host write in the same cycle on a non-full FIFO both take effect; level is unchanged.
- RX FIFO:
  - rx_rd_en while rx_empty is ignored; rx_rd_data holds.
  - A push and a pop in the same cycle both take effect; a pop at full in the same cycle as a push does not overflow.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Levels saturate at FIFO_DEPTH by construction.
- irq_status:
  - Each bit is set by its event and cleared by the matching irq_clear bit.
  - A set event has priority over a clear in the same cycle.
  - irq updates one cycle after irq_status.

Test Plan:
1. Mode 0, 16-bit, host writes 0xAA55 to TX; master sends 0x1234 with one ss_n frame -> miso shifts out 0xAA55 MSB first; rx_rd_data=0x1234; rx_level=1; irq_status=4'b0001; irq=1 with irq_enable=4'b0001.
2. Back-to-back: TX loaded with 0x0000, 0x1111, 0x2222; three words in one ss_n-low frame with master sending 0xCCCC each -> miso carries 0x0000, 0x1111, 0x2222; rx_level=3; no underflow.
3. Overflow: 5 words received with no reads at FIFO_DEPTH=4 -> rx_level=4, rx_overflow=1, head still holds word 1; irq_clear=4'b0010 clears bit 1 only.
4. Underflow: TX FIFO empty at ss_n fall -> miso=0 for all 16 bits; tx_underflow=1; the received word is still stored.
5. Abort: ss_n released after 7 sclk cycles -> frame_abort=1, rx_level unchanged, state IDLE, miso_oe=0; the next full frame receives correctly.
6. Reset mid-frame at bit 9 with 2 words queued in TX -> all outputs at reset values; a following frame shows tx_underflow=1.
